// File: rtl/gerenciador_botoes_pkg.sv
// Shared types and width helpers for the button manager.
package gerenciador_botoes_pkg;

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        OFERTA = 1'b1
    } estado_arb_t;

    function automatic int largura_id(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int largura_cnt(input int amostras);
        return $clog2(amostras + 1);
    endfunction

endpackage

// File: rtl/filtro_botao.sv
// One button: synchronizer, tick-sampled debounce counter and rise pulse.
module filtro_botao
    import gerenciador_botoes_pkg::*;
#(
    parameter int AMOSTRAS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic bruto_i,
    output logic estavel_o,
    output logic subida_o
);

    localparam int CW = largura_cnt(AMOSTRAS);
    localparam logic [CW:0] ALVO = (CW + 1)'(AMOSTRAS);

    logic          sinc1_q, sinc2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          estavel_q, estavel_d;
    logic          subida_q, subida_d;
    logic [CW:0]   prox;

    assign prox = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        cnt_d     = cnt_q;
        estavel_d = estavel_q;
        if (tick_i) begin
            if (sinc2_q == estavel_q) begin
                cnt_d = '0;
            end else if (prox == ALVO) begin
                cnt_d     = '0;
                estavel_d = ~estavel_q;
            end else begin
                cnt_d = prox[CW-1:0];
            end
        end
        subida_d = estavel_d & ~estavel_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1_q   <= 1'b0;
            sinc2_q   <= 1'b0;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
            subida_q  <= 1'b0;
        end else begin
            sinc1_q   <= bruto_i;
            sinc2_q   <= sinc1_q;
            cnt_q     <= cnt_d;
            estavel_q <= estavel_d;
            subida_q  <= subida_d;
        end
    end

    assign estavel_o = estavel_q;
    assign subida_o  = subida_q;

endmodule

// File: rtl/gerenciador_botoes.sv
// Debounced buttons become pending events offered one at a time.
module gerenciador_botoes
    import gerenciador_botoes_pkg::*;
#(
    parameter int N_BOTOES    = 4,
    parameter int DIV_AMOSTRA = 50000,
    parameter int AMOSTRAS    = 3,
    localparam int W = largura_id(N_BOTOES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] estado_estavel,
    output logic                evento_valido,
    output logic [W-1:0]        evento_id,
    input  logic                evento_ack,
    output logic                perdido
);

    localparam int DW = $clog2(DIV_AMOSTRA);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV_AMOSTRA - 1);

    logic [DW-1:0]       div_q;
    logic                tick;
    logic [N_BOTOES-1:0] subida;
    logic [N_BOTOES-1:0] pend_q, pend_d, limpa;
    logic                perdido_q, perdido_d;
    estado_arb_t         estado_q, estado_d;
    logic                valido_q, valido_d;
    logic [W-1:0]        id_q, id_d, menor;
    logic                aceito;

    assign tick = (div_q == DIV_MAX);

    always_ff @(posedge clock) begin
        if (reset) div_q <= '0;
        else       div_q <= tick ? '0 : div_q + 1'b1;
    end

    for (genvar g = 0; g < N_BOTOES; g++) begin : g_filtro
        filtro_botao #(
            .AMOSTRAS(AMOSTRAS)
        ) u_filtro (
            .clock    (clock),
            .reset    (reset),
            .tick_i   (tick),
            .bruto_i  (botoes[g]),
            .estavel_o(estado_estavel[g]),
            .subida_o (subida[g])
        );
    end

    assign aceito = (estado_q == OFERTA) & evento_ack;

    // A new rise beats a same-cycle clear, so the press is re-offered.
    always_comb begin
        limpa = '0;
        for (int i = 0; i < N_BOTOES; i++)
            limpa[i] = aceito && (id_q == W'(i));
        pend_d    = (pend_q & ~limpa) | subida;
        perdido_d = |(subida & pend_q & ~limpa);
    end

    always_comb begin
        menor = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--)
            if (pend_q[i]) menor = W'(i);
    end

    always_comb begin
        estado_d = estado_q;
        valido_d = valido_q;
        id_d     = id_q;
        unique case (estado_q)
            OCIOSO: begin
                if (|pend_q) begin
                    estado_d = OFERTA;
                    valido_d = 1'b1;
                    id_d     = menor;
                end
            end
            OFERTA: begin
                if (evento_ack) begin
                    estado_d = OCIOSO;
                    valido_d = 1'b0;
                end
            end
            default: begin
                estado_d = OCIOSO;
                valido_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q    <= '0;
            perdido_q <= 1'b0;
            estado_q  <= OCIOSO;
            valido_q  <= 1'b0;
            id_q      <= '0;
        end else begin
            pend_q    <= pend_d;
            perdido_q <= perdido_d;
            estado_q  <= estado_d;
            valido_q  <= valido_d;
            id_q      <= id_d;
        end
    end

    assign evento_valido = valido_q;
    assign evento_id     = id_q;
    assign perdido       = perdido_q;

endmodule
